// File: rtl/lut_code_pkg.sv
// ============================================================================
// lut_code_pkg -- legal 3b->4b lane codewords, canonical values, FSM states
// Rev 1.0
// ============================================================================
`default_nettype none

package lut_code_pkg;

    localparam int LANE_CW = 4;
    localparam int LANE_DW = 3;

    localparam logic [LANE_CW-1:0] CW_000 = 4'b0000;
    localparam logic [LANE_CW-1:0] CW_001 = 4'b0101;
    localparam logic [LANE_CW-1:0] CW_011 = 4'b0110;
    localparam logic [LANE_CW-1:0] CW_100 = 4'b1001;
    localparam logic [LANE_CW-1:0] CW_101 = 4'b1010;
    localparam logic [LANE_CW-1:0] CW_111 = 4'b1111;

    localparam logic [LANE_DW-1:0] DV_000 = 3'b000;
    localparam logic [LANE_DW-1:0] DV_001 = 3'b001;
    localparam logic [LANE_DW-1:0] DV_011 = 3'b011;
    localparam logic [LANE_DW-1:0] DV_100 = 3'b100;
    localparam logic [LANE_DW-1:0] DV_101 = 3'b101;
    localparam logic [LANE_DW-1:0] DV_111 = 3'b111;

    typedef enum logic [1:0] {
        OK      = 2'd0,
        SUSPECT = 2'd1,
        FAULT   = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/lut_code_dec_lane.sv
// ============================================================================
// lut_code_dec_lane -- combinational 4b codeword -> {3b canonical value, err}
// Rev 1.0
// ============================================================================
`default_nettype none

module lut_code_dec_lane
    import lut_code_pkg::*;
(
    input  logic [LANE_CW-1:0] code,
    output logic [LANE_DW-1:0] value,
    output logic               err
);

    always_comb begin
        value = DV_000;
        err   = 1'b0;
        case (code)
            CW_000:  value = DV_000;
            CW_001:  value = DV_001;
            CW_011:  value = DV_011;
            CW_100:  value = DV_100;
            CW_101:  value = DV_101;
            CW_111:  value = DV_111;
            default: err   = 1'b1;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/lut_code_decoder.sv
// ============================================================================
// lut_code_decoder -- lane-code receive decoder with sticky fault FSM.
// Optional LUT_DEC_HOLD_LAST_EN: illegal lanes repeat last legal lane value.
// Rev 1.0
// ============================================================================
`default_nettype none

module lut_code_decoder
    import lut_code_pkg::*;
#(
    parameter int N_LANES    = 4,
    parameter int CNT_W      = 8,
    parameter int ERR_THRESH = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [LANE_CW*N_LANES-1:0] in_code,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [LANE_DW*N_LANES-1:0] out_data,
    output logic [N_LANES-1:0]         out_err,
    input  logic                       clr_fault,
    output logic                       fault,
    output logic [CNT_W-1:0]           err_cnt
);

    localparam logic [3:0] c_thresh = 4'(ERR_THRESH);

    logic [LANE_DW*N_LANES-1:0] w_val;
    logic [LANE_DW*N_LANES-1:0] w_sel;
    logic [N_LANES-1:0]         w_lerr;
    logic                       w_accept;
    logic                       w_beat_err;

    logic                       r_out_valid;
    logic [LANE_DW*N_LANES-1:0] r_out_data;
    logic [N_LANES-1:0]         r_out_err;
    logic [CNT_W-1:0]           r_err_cnt;
    state_t                     r_state;
    state_t                     w_state_nxt;
    logic [3:0]                 r_run;
    logic [3:0]                 w_run_nxt;

    generate
        for (genvar i = 0; i < N_LANES; i++) begin : g_lane
            lut_code_dec_lane u_lane (
                .code  (in_code[LANE_CW*i +: LANE_CW]),
                .value (w_val[LANE_DW*i +: LANE_DW]),
                .err   (w_lerr[i])
            );
        end
    endgenerate

`ifdef LUT_DEC_HOLD_LAST_EN
    logic [LANE_DW*N_LANES-1:0] r_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= '0;
        end else if (w_accept) begin
            for (int i = 0; i < N_LANES; i++) begin
                if (!w_lerr[i]) r_last[LANE_DW*i +: LANE_DW] <= w_val[LANE_DW*i +: LANE_DW];
            end
        end
    end

    always_comb begin
        w_sel = w_val;
        for (int i = 0; i < N_LANES; i++) begin
            if (w_lerr[i]) w_sel[LANE_DW*i +: LANE_DW] = r_last[LANE_DW*i +: LANE_DW];
        end
    end
`else
    assign w_sel = w_val;
`endif

    assign in_ready   = !r_out_valid || out_ready;
    assign w_accept   = in_valid && in_ready;
    assign w_beat_err = |w_lerr;

    // Single output stage: refill on accept, empty only when downstream takes it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_err   <= '0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_sel;
            r_out_err   <= w_lerr;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // clr_fault overrides the state update; an erroneous beat in that cycle opens a new run
    always_comb begin
        w_state_nxt = r_state;
        w_run_nxt   = r_run;
        if (clr_fault) begin
            w_state_nxt = OK;
            w_run_nxt   = 4'd0;
            if (w_accept && w_beat_err) begin
                w_run_nxt   = 4'd1;
                w_state_nxt = (c_thresh == 4'd1) ? FAULT : SUSPECT;
            end
        end else if (w_accept) begin
            case (r_state)
                OK: begin
                    if (w_beat_err) begin
                        w_run_nxt   = 4'd1;
                        w_state_nxt = (c_thresh == 4'd1) ? FAULT : SUSPECT;
                    end
                end
                SUSPECT: begin
                    if (w_beat_err) begin
                        w_run_nxt = r_run + 4'd1;
                        if (r_run + 4'd1 == c_thresh) w_state_nxt = FAULT;
                    end else begin
                        w_run_nxt   = 4'd0;
                        w_state_nxt = OK;
                    end
                end
                FAULT: begin
                    w_state_nxt = FAULT;
                end
                default: begin
                    w_state_nxt = OK;
                    w_run_nxt   = 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= OK;
            r_run   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_run   <= w_run_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_cnt <= '0;
        end else if (w_accept && w_beat_err && (r_err_cnt != {CNT_W{1'b1}})) begin
            r_err_cnt <= r_err_cnt + CNT_W'(1);
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_err   = r_out_err;
    assign fault     = (r_state == FAULT);
    assign err_cnt   = r_err_cnt;

endmodule

`default_nettype wire

// File: tb/tb_lut_code_decoder.sv
// ============================================================================
// tb_lut_code_decoder -- table vectors, scoreboard, FSM/reset corner sequences
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_lut_code_decoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic        clr_fault = 1'b0;
    logic [15:0] in_code = '0;
    logic        in_ready, out_valid, fault;
    logic [11:0] out_data;
    logic [3:0]  out_err;
    logic [7:0]  err_cnt;

    logic        s_in_ready, s_out_valid, s_fault;
    logic [11:0] s_out_data;
    logic [3:0]  s_out_err;
    logic [1:0]  s_err_cnt;

    always #5 clk = ~clk;

    lut_code_decoder #(.N_LANES(4), .CNT_W(8), .ERR_THRESH(3)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_code(in_code), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_err(out_err), .clr_fault(clr_fault),
        .fault(fault), .err_cnt(err_cnt)
    );

    lut_code_decoder #(.N_LANES(4), .CNT_W(2), .ERR_THRESH(3)) dut_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_code(in_code), .out_valid(s_out_valid), .out_ready(out_ready),
        .out_data(s_out_data), .out_err(s_out_err), .clr_fault(clr_fault),
        .fault(s_fault), .err_cnt(s_err_cnt)
    );

    typedef struct {
        logic [3:0] code;
        logic [2:0] dat;
        logic       err;
    } vec_t;

    typedef struct {
        logic [11:0] d;
        logic [3:0]  e;
    } exp_t;

    vec_t        tbl [16];
    exp_t        sbq [$];
    logic [11:0] m_last;
    int          checks = 0;
    int          errors = 0;
    int          n_acc = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic dec1(input logic [3:0] c, output logic [2:0] v);
        v = 3'b000;
        dec1 = 1'b0;
        case (c)
            4'b0000: v = 3'b000;
            4'b0101: v = 3'b001;
            4'b0110: v = 3'b011;
            4'b1001: v = 3'b100;
            4'b1010: v = 3'b101;
            4'b1111: v = 3'b111;
            default: dec1 = 1'b1;
        endcase
    endfunction

    // Reference decode of a whole beat; advances the held-value model
    function automatic exp_t model(input logic [15:0] code);
        exp_t       r;
        logic [2:0] v;
        for (int i = 0; i < 4; i++) begin
            r.e[i] = dec1(code[4*i +: 4], v);
            if (r.e[i]) begin
`ifdef LUT_DEC_HOLD_LAST_EN
                r.d[3*i +: 3] = m_last[3*i +: 3];
`else
                r.d[3*i +: 3] = 3'b000;
`endif
            end else begin
                r.d[3*i +: 3]      = v;
                m_last[3*i +: 3] = v;
            end
        end
        return r;
    endfunction

    task automatic sample();
        exp_t x;
        if (out_valid && out_ready) begin
            if (sbq.size() == 0) begin
                chk("sb_underflow", 1, 0);
            end else begin
                x = sbq.pop_front();
                chk("sb_data", out_data, x.d);
                chk("sb_err", out_err, x.e);
            end
        end
        if (in_valid && in_ready) begin
            sbq.push_back(model(in_code));
            n_acc++;
        end
    endtask

    // Called at a negedge with inputs set; returns at the following negedge
    task automatic cycle();
        #1;
        sample();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        clr_fault = 1'b0;
        out_ready = 1'b1;
        in_code   = '0;
        sbq.delete();
        m_last = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic beat(input logic e);
        in_valid = 1'b1;
        in_code  = e ? 16'h0003 : 16'h0005;
        cycle();
    endtask

    initial begin
        logic [2:0]  tl, ev;
        logic [11:0] held;
        int          cyc;

        tbl[0]  = '{4'h0, 3'b000, 1'b0}; tbl[1]  = '{4'h1, 3'b000, 1'b1};
        tbl[2]  = '{4'h2, 3'b000, 1'b1}; tbl[3]  = '{4'h3, 3'b000, 1'b1};
        tbl[4]  = '{4'h4, 3'b000, 1'b1}; tbl[5]  = '{4'h5, 3'b001, 1'b0};
        tbl[6]  = '{4'h6, 3'b011, 1'b0}; tbl[7]  = '{4'h7, 3'b000, 1'b1};
        tbl[8]  = '{4'h8, 3'b000, 1'b1}; tbl[9]  = '{4'h9, 3'b100, 1'b0};
        tbl[10] = '{4'hA, 3'b101, 1'b0}; tbl[11] = '{4'hB, 3'b000, 1'b1};
        tbl[12] = '{4'hC, 3'b000, 1'b1}; tbl[13] = '{4'hD, 3'b000, 1'b1};
        tbl[14] = '{4'hE, 3'b000, 1'b1}; tbl[15] = '{4'hF, 3'b111, 1'b0};

        @(negedge clk);
        do_reset();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_err", out_err, 0);
        chk("rst_fault", fault, 0);
        chk("rst_err_cnt", err_cnt, 0);

        // All 16 codes in lane 0
        tl = 3'b000;
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            in_code  = {12'h000, tbl[i].code};
            cycle();
            if (tbl[i].err) begin
`ifdef LUT_DEC_HOLD_LAST_EN
                ev = tl;
`else
                ev = 3'b000;
`endif
            end else begin
                ev = tbl[i].dat;
                tl = tbl[i].dat;
            end
            chk("tbl_valid", out_valid, 1);
            chk("tbl_data", out_data[2:0], ev);
            chk("tbl_err", out_err[0], tbl[i].err);
            chk("tbl_other_lanes", {out_data[11:3], out_err[3:1]}, 0);
        end
        in_valid = 1'b0;
        cycle();
        chk("tbl_err_cnt", err_cnt, 10);
        chk("tbl_sat_err_cnt", s_err_cnt, 3);

        // Error run: err,err,clean,err,err,err
        do_reset();
        beat(1); chk("run1_fault", fault, 0);
        beat(1); chk("run2_fault", fault, 0);
        beat(0); chk("run3_fault", fault, 0);
        beat(1); chk("run4_fault", fault, 0);
        beat(1); chk("run5_fault", fault, 0);
        beat(1); chk("run6_fault", fault, 1);
        in_valid = 1'b0;
        cycle();
        chk("run_err_cnt", err_cnt, 5);
        chk("sat_err_cnt", s_err_cnt, 3);
        chk("sat_fault", s_fault, 1);

        // clr_fault with erroneous beat starts a new run at 1
        clr_fault = 1'b1; beat(1); clr_fault = 1'b0;
        chk("clr_err_fault", fault, 0);
        beat(1); chk("clr_err_run2", fault, 0);
        beat(1); chk("clr_err_run3", fault, 1);
        // clr_fault with clean beat returns to OK with run 0
        clr_fault = 1'b1; beat(0); clr_fault = 1'b0;
        chk("clr_ok_fault", fault, 0);
        beat(1); chk("clr_ok_run1", fault, 0);
        beat(1); chk("clr_ok_run2", fault, 0);
        beat(1); chk("clr_ok_run3", fault, 1);
        in_valid = 1'b0;
        cycle();
        chk("clr_err_cnt", err_cnt, 11);

        // Backpressure: hold beat for 3 cycles
        do_reset();
        in_valid = 1'b1; in_code = 16'hF96A;
        cycle();
        out_ready = 1'b0; in_code = 16'h5A05;
        held = out_data;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("stall_in_ready", in_ready, 0);
            chk("stall_valid", out_valid, 1);
            chk("stall_data", out_data, held);
        end
        out_ready = 1'b1;
        cycle();
        in_valid = 1'b0;
        cycle();
        chk("stall_sb_empty", sbq.size(), 0);

        // Random traffic
        n_acc = 0;
        cyc = 0;
        while (n_acc < 100 && cyc < 2000) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            for (int l = 0; l < 4; l++) begin
                case ($urandom_range(0, 7))
                    0: in_code[4*l +: 4] = 4'b0000;
                    1: in_code[4*l +: 4] = 4'b0101;
                    2: in_code[4*l +: 4] = 4'b0110;
                    3: in_code[4*l +: 4] = 4'b1001;
                    4: in_code[4*l +: 4] = 4'b1010;
                    5: in_code[4*l +: 4] = 4'b1111;
                    default: in_code[4*l +: 4] = 4'($urandom);
                endcase
            end
            cycle();
            cyc++;
        end
        chk("rand_accepts", n_acc >= 100, 1);
        in_valid = 1'b0; out_ready = 1'b1;
        cyc = 0;
        while (sbq.size() != 0 && cyc < 10) begin
            cycle();
            cyc++;
        end
        chk("rand_sb_drain", sbq.size(), 0);

        // Illegal lane after a legal one
        do_reset();
        in_valid = 1'b1; in_code = 16'h0006;
        cycle();
        chk("hold_first", out_data[2:0], 3'b011);
        in_code = 16'h0003;
        cycle();
`ifdef LUT_DEC_HOLD_LAST_EN
        chk("hold_second", out_data[2:0], 3'b011);
`else
        chk("hold_second", out_data[2:0], 3'b000);
`endif
        chk("hold_second_err", out_err[0], 1);

        // Asynchronous reset while in FAULT with a beat held
        in_code = 16'h0003;
        cycle(); cycle();
        chk("pre_rst_fault", fault, 1);
        out_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_out_data", out_data, 0);
        chk("arst_out_err", out_err, 0);
        chk("arst_fault", fault, 0);
        chk("arst_err_cnt", err_cnt, 0);
        chk("arst_in_ready", in_ready, 1);
        @(negedge clk);
        do_reset();
        chk("post_rst_valid", out_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
